uart_pkt_rx: RTL and testbench

- Framed-packet receiver between the UART byte receiver and downstream consumers. Successor to the plain uart2fifo path.
- Parses HEADER / LEN / payload / CHK frames from the UART byte stream.
- Buffers the payload in an internal store-and-forward FIFO of parametrised depth. A packet is committed only when its checksum is good.
- Reports last packet length, packet count and error counters. A checksum bypass mode is available.

---
 rtl/uart_pkt_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_pkt_rx.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_rx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_pkt_rx : framed-packet receiver (HEADER / LEN / payload / CHK) feeding a
//               store-and-forward FIFO; payload is visible only after commit.
// Revision    : 1.0
// -----------------------------------------------------------------------------
module uart_pkt_rx #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_LEN     = 255,
  parameter bit          CHK_EN      = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_data_valid,
  output logic            rx_data_ready,
  output logic [7:0]      m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            pkt_done,
  output logic [7:0]      pkt_len,
  output logic [15:0]     pkt_cnt,
  output logic [7:0]      err_chk,
  output logic [7:0]      err_drop,
  output logic [ADDR_W:0] fill
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, wr_tmp, rd_ptr, wr_tmp_nxt;
  logic [7:0]      len, sum;
  logic [8:0]      remain;
  logic [31:0]     idle_cnt, free_space;
  logic            accept, timeout, avail, load;
  logic            do_write, do_commit, do_rollback;
  logic            inc_drop, inc_chk, ld_pay, ld_drop;

  assign rx_data_ready = 1'b1;
  assign accept        = rx_data_valid && rx_data_ready;
  assign fill          = wr_ptr - rd_ptr;
  // Space left for a new packet: the output register holds one slot as well.
  assign free_space    = 32'(DEPTH) - 32'(fill) - 32'(m_valid);
  assign timeout       = (state != S_IDLE) && !accept &&
                         (idle_cnt >= 32'(TIMEOUT_CYC - 1));
  assign avail         = (wr_ptr != rd_ptr);
  assign load          = (!m_valid || m_ready) && avail;
  assign wr_tmp_nxt    = do_rollback ? wr_ptr :
                         (do_write ? wr_tmp + PTR_ONE : wr_tmp);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    inc_drop    = 1'b0;
    inc_chk     = 1'b0;
    ld_pay      = 1'b0;
    ld_drop     = 1'b0;
    if (timeout) begin
      do_rollback = 1'b1;
      inc_drop    = (state != S_DROP);
      state_nxt   = S_IDLE;
    end else if (accept) begin
      case (state)
        S_IDLE: if (rx_data == HEADER) state_nxt = S_LEN;
        S_LEN: begin
          if (rx_data == 8'd0 || 32'(rx_data) > MAX_LEN) begin
            inc_drop  = 1'b1;
            state_nxt = S_IDLE;
          end else if (32'(rx_data) > free_space) begin
            inc_drop  = 1'b1;
            ld_drop   = 1'b1;
            state_nxt = S_DROP;
          end else begin
            ld_pay    = 1'b1;
            state_nxt = S_PAY;
          end
        end
        S_PAY: begin
          do_write = 1'b1;
          if (remain == 9'd1) begin
            if (CHK_EN) begin
              state_nxt = S_CHK;
            end else begin
              do_commit = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_CHK: begin
          if (rx_data == sum) begin
            do_commit = 1'b1;
          end else begin
            inc_chk     = 1'b1;
            do_rollback = 1'b1;
          end
          state_nxt = S_IDLE;
        end
        S_DROP:  if (remain == 9'd1) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_tmp   <= '0;
      len      <= '0;
      sum      <= '0;
      remain   <= '0;
      idle_cnt <= '0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_cnt  <= '0;
      err_chk  <= '0;
      err_drop <= '0;
    end else begin
      wr_tmp   <= wr_tmp_nxt;
      pkt_done <= do_commit;
      if (do_commit) begin
        wr_ptr  <= wr_tmp_nxt;
        pkt_len <= len;
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (accept && state == S_LEN) begin
        len <= rx_data;
        sum <= rx_data;
      end else if (do_write) begin
        sum <= sum + rx_data;
      end
      if (ld_pay)
        remain <= {1'b0, rx_data};
      else if (ld_drop)
        remain <= {1'b0, rx_data} + (CHK_EN ? 9'd1 : 9'd0);
      else if (accept && (state == S_PAY || state == S_DROP))
        remain <= remain - 9'd1;
      if (accept || timeout || state == S_IDLE) idle_cnt <= '0;
      else                                      idle_cnt <= idle_cnt + 32'd1;
      if (inc_chk && err_chk != 8'hFF)   err_chk  <= err_chk + 8'd1;
      if (inc_drop && err_drop != 8'hFF) err_drop <= err_drop + 8'd1;
    end
  end

  // Payload storage is not reset; only committed slots are ever read.
  always_ff @(posedge sys_clk) begin
    if (do_write) mem[wr_tmp[ADDR_W-1:0]] <= rx_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_data  <= mem[rd_ptr[ADDR_W-1:0]];
      m_valid <= 1'b1;
      rd_ptr  <= rd_ptr + PTR_ONE;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_rx.sv
`default_nettype none
// tb_uart_pkt_rx : directed and randomized checks of uart_pkt_rx against a
// frame-level model (expected byte queue plus expected counters).
module tb_uart_pkt_rx;
  localparam int         TO  = 40;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0]  rxd   [3];
  logic        rxv   [3];
  logic        rdy   [3];
  logic        mrdy  [3];
  logic [7:0]  mdat  [3];
  logic        mval  [3];
  logic        done  [3];
  logic [7:0]  plen  [3];
  logic [15:0] pcnt  [3];
  logic [7:0]  echk  [3];
  logic [7:0]  edrop [3];
  logic [8:0]  fill_m, fill_n;
  logic [3:0]  fill_s;

  int vectors = 0, miscompares = 0;
  int done_cnt [3];
  logic [7:0] got0[$], got1[$], got2[$];
  int exp_cnt = 0, exp_chk = 0, exp_drop = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_pkt_rx #(.HEADER(HDR), .ADDR_W(8), .MAX_LEN(255), .CHK_EN(1'b1), .TIMEOUT_CYC(TO)) u_main (
    .sys_clk(clk), .rst_n(rst_n), .rx_data(rxd[0]), .rx_data_valid(rxv[0]), .rx_data_ready(rdy[0]),
    .m_data(mdat[0]), .m_valid(mval[0]), .m_ready(mrdy[0]), .pkt_done(done[0]), .pkt_len(plen[0]),
    .pkt_cnt(pcnt[0]), .err_chk(echk[0]), .err_drop(edrop[0]), .fill(fill_m));

  uart_pkt_rx #(.HEADER(HDR), .ADDR_W(3), .MAX_LEN(8), .CHK_EN(1'b1), .TIMEOUT_CYC(TO)) u_small (
    .sys_clk(clk), .rst_n(rst_n), .rx_data(rxd[1]), .rx_data_valid(rxv[1]), .rx_data_ready(rdy[1]),
    .m_data(mdat[1]), .m_valid(mval[1]), .m_ready(mrdy[1]), .pkt_done(done[1]), .pkt_len(plen[1]),
    .pkt_cnt(pcnt[1]), .err_chk(echk[1]), .err_drop(edrop[1]), .fill(fill_s));

  uart_pkt_rx #(.HEADER(HDR), .ADDR_W(8), .MAX_LEN(255), .CHK_EN(1'b0), .TIMEOUT_CYC(TO)) u_nochk (
    .sys_clk(clk), .rst_n(rst_n), .rx_data(rxd[2]), .rx_data_valid(rxv[2]), .rx_data_ready(rdy[2]),
    .m_data(mdat[2]), .m_valid(mval[2]), .m_ready(mrdy[2]), .pkt_done(done[2]), .pkt_len(plen[2]),
    .pkt_cnt(pcnt[2]), .err_chk(echk[2]), .err_drop(edrop[2]), .fill(fill_n));

  // Consumer side: record every byte handed over and every commit pulse.
  always @(negedge clk) begin
    if (mval[0] && mrdy[0]) got0.push_back(mdat[0]);
    if (mval[1] && mrdy[1]) got1.push_back(mdat[1]);
    if (mval[2] && mrdy[2]) got2.push_back(mdat[2]);
    for (int i = 0; i < 3; i++) if (done[i]) done_cnt[i]++;
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) mrdy[0] = ($urandom_range(3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int d, input logic [7:0] b);
    rxd[d] = b; rxv[d] = 1'b1; tick(); rxv[d] = 1'b0;
  endtask

  // Checksum = (LEN + sum of payload) mod 256; bad frames send its complement.
  task automatic send_frame(input int d, input logic [7:0] pl[$], input bit with_chk, input bit bad);
    logic [7:0] s;
    s = 8'(pl.size());
    send(d, HDR); send(d, s);
    foreach (pl[k]) begin send(d, pl[k]); s = s + pl[k]; end
    if (with_chk) send(d, bad ? ~s : s);
  endtask

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({rdy[i], mval[i], done[i], plen[i], pcnt[i], echk[i], edrop[i], mdat[i]} !==
          {1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 8'd0, 8'd0, 8'd0}) begin
        miscompares++;
        $display("FAIL reset_outs[%0d]: rdy=%b mval=%b done=%b len=%0d cnt=%0d echk=%0d edrop=%0d mdat=%h, want rdy=1 rest 0",
                 i, rdy[i], mval[i], done[i], plen[i], pcnt[i], echk[i], edrop[i], mdat[i]);
      end
    end
    vectors++;
    if ({fill_m, fill_s, fill_n} !== '0) begin
      miscompares++; $display("FAIL reset_fill: got %0d/%0d/%0d want 0/0/0", fill_m, fill_s, fill_n);
    end
  endtask

  task automatic test_good_frame();
    int base = got0.size(); int dc = done_cnt[0];
    mrdy[0] = 1'b1;
    send(0, HDR); send(0, 8'h03); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h69);
    exp_cnt++;
    vectors++;
    if ({done[0], mval[0], fill_m} !== {1'b1, 1'b0, 9'd3}) begin
      miscompares++; $display("FAIL good_commit_cycle: done=%b mval=%b fill=%0d want 1 0 3", done[0], mval[0], fill_m);
    end
    tick();
    vectors++;
    if ({mval[0], mdat[0], done[0]} !== {1'b1, 8'h11, 1'b0}) begin
      miscompares++; $display("FAIL good_first_byte: mval=%b mdat=%h done=%b want 1 11 0", mval[0], mdat[0], done[0]);
    end
    idle(6);
    vectors++;
    if ({plen[0], pcnt[0], fill_m} !== {8'd3, 16'(exp_cnt), 9'd0} || done_cnt[0] - dc != 1) begin
      miscompares++; $display("FAIL good_status: len=%0d cnt=%0d fill=%0d pulses=%0d want 3 %0d 0 1",
                              plen[0], pcnt[0], fill_m, done_cnt[0] - dc, exp_cnt);
    end
    vectors++;
    if (got0.size() != base + 3 || got0[base] !== 8'h11 || got0[base+1] !== 8'h22 || got0[base+2] !== 8'h33) begin
      miscompares++; $display("FAIL good_data: got %0d bytes want 11 22 33", got0.size() - base);
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] pl[$];
    int base = got0.size(); int dc = done_cnt[0];
    send(0, HDR); send(0, 8'h03); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h00);
    exp_chk = sat(exp_chk);
    idle(4);
    vectors++;
    if ({echk[0], mval[0], fill_m} !== {8'(exp_chk), 1'b0, 9'd0} || done_cnt[0] != dc || got0.size() != base) begin
      miscompares++; $display("FAIL badchk_status: echk=%0d mval=%b fill=%0d pulses=%0d bytes=%0d want %0d 0 0 0 0",
                              echk[0], mval[0], fill_m, done_cnt[0] - dc, got0.size() - base, exp_chk);
    end
    pl = {8'h5A, 8'h01};
    send_frame(0, pl, 1'b1, 1'b0);
    exp_cnt++;
    idle(6);
    vectors++;
    if (got0.size() != base + 2 || got0[base] !== 8'h5A || got0[base+1] !== 8'h01 || pcnt[0] !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL badchk_recover: bytes=%0d cnt=%0d want 2 bytes 5A 01 cnt %0d", got0.size() - base, pcnt[0], exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int base = got0.size();
    send(0, HDR); send(0, 8'h05); send(0, 8'h01); send(0, 8'h02);
    idle(TO - 3);
    vectors++;
    if (edrop[0] !== 8'(exp_drop)) begin
      miscompares++; $display("FAIL timeout_early: edrop=%0d want %0d", edrop[0], exp_drop);
    end
    idle(5);
    exp_drop = sat(exp_drop);
    vectors++;
    if ({edrop[0], fill_m, mval[0]} !== {8'(exp_drop), 9'd0, 1'b0}) begin
      miscompares++; $display("FAIL timeout_drop: edrop=%0d fill=%0d mval=%b want %0d 0 0", edrop[0], fill_m, mval[0], exp_drop);
    end
    send(0, HDR); send(0, 8'h01); send(0, 8'h7E); send(0, 8'h7F);
    exp_cnt++;
    idle(5);
    vectors++;
    if (got0.size() != base + 1 || got0[base] !== 8'h7E || pcnt[0] !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL timeout_recover: bytes=%0d cnt=%0d want one byte 7E cnt %0d", got0.size() - base, pcnt[0], exp_cnt);
    end
  endtask

  task automatic test_stall_toggle();
    logic [7:0] pl[$];
    logic pv, pr; logic [7:0] pd;
    int base = got0.size(); int ok = 1;
    mrdy[0] = 1'b0;
    for (int k = 0; k < 4; k++) pl.push_back(8'($urandom));
    send_frame(0, pl, 1'b1, 1'b0);
    exp_cnt++;
    idle(3);
    vectors++;
    if ({mval[0], mdat[0], fill_m} !== {1'b1, pl[0], 9'd3}) begin
      miscompares++; $display("FAIL stall_hold_start: mval=%b mdat=%h fill=%0d want 1 %h 3", mval[0], mdat[0], fill_m, pl[0]);
    end
    for (int c = 0; c < 16; c++) begin
      pv = mval[0]; pd = mdat[0];
      mrdy[0] = (c % 2 == 0); pr = mrdy[0];
      tick();
      if (pv && !pr && (mval[0] !== 1'b1 || mdat[0] !== pd)) ok = 0;
    end
    vectors++;
    if (ok == 0) begin
      miscompares++; $display("FAIL stall_stable: m_data/m_valid changed while stalled, want held");
    end
    vectors++;
    if (got0.size() != base + 4 || got0[base] !== pl[0] || got0[base+1] !== pl[1] ||
        got0[base+2] !== pl[2] || got0[base+3] !== pl[3]) begin
      miscompares++; $display("FAIL stall_data: got %0d bytes want 4 (%h %h %h %h)", got0.size() - base, pl[0], pl[1], pl[2], pl[3]);
    end
    mrdy[0] = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] expq[$];
    logic [7:0] pl[$];
    logic [7:0] junk;
    int base = got0.size(); int kind, last_len, bad;
    last_len = plen[0];
    rand_rdy = 1'b1;
    for (int p = 0; p < 25; p++) begin
      repeat ($urandom_range(2)) begin
        junk = 8'($urandom);
        if (junk == HDR) junk = 8'h00;
        send(0, junk);
      end
      kind = $urandom_range(7);
      if (kind == 0) begin
        send(0, HDR); send(0, 8'h00);
        exp_drop = sat(exp_drop);
      end else begin
        pl.delete();
        repeat ($urandom_range(8, 1)) pl.push_back(8'($urandom));
        send_frame(0, pl, 1'b1, kind == 1);
        if (kind == 1) exp_chk = sat(exp_chk);
        else begin
          foreach (pl[k]) expq.push_back(pl[k]);
          exp_cnt++; last_len = pl.size();
        end
      end
      idle($urandom_range(2));
    end
    rand_rdy = 1'b0; mrdy[0] = 1'b1;
    idle(40);
    bad = 0;
    vectors++;
    if (got0.size() != base + expq.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d bytes want %0d", got0.size() - base, expq.size());
    end else begin
      foreach (expq[k]) if (got0[base+k] !== expq[k]) bad++;
      if (bad != 0) begin
        miscompares++; $display("FAIL rand_data: %0d bytes differ from model", bad);
      end
    end
    vectors++;
    if ({pcnt[0], echk[0], edrop[0], plen[0], fill_m} !== {16'(exp_cnt), 8'(exp_chk), 8'(exp_drop), 8'(last_len), 9'd0}) begin
      miscompares++; $display("FAIL rand_counters: cnt=%0d echk=%0d edrop=%0d len=%0d fill=%0d want %0d %0d %0d %0d 0",
                              pcnt[0], echk[0], edrop[0], plen[0], fill_m, exp_cnt, exp_chk, exp_drop, last_len);
    end
  endtask

  task automatic test_no_space();
    logic [7:0] pl[$];
    int base = got1.size();
    mrdy[1] = 1'b0;
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(1, pl, 1'b1, 1'b0);
    idle(3);
    vectors++;
    if ({pcnt[1], fill_s, mval[1], mdat[1]} !== {16'd1, 4'd5, 1'b1, 8'h01}) begin
      miscompares++; $display("FAIL nospace_first: cnt=%0d fill=%0d mval=%b mdat=%h want 1 5 1 01", pcnt[1], fill_s, mval[1], mdat[1]);
    end
    pl = {8'h09, 8'hA5, 8'h09, 8'h09};
    send_frame(1, pl, 1'b1, 1'b0);
    idle(2);
    vectors++;
    if ({edrop[1], pcnt[1], fill_s} !== {8'd1, 16'd1, 4'd5}) begin
      miscompares++; $display("FAIL nospace_drop: edrop=%0d cnt=%0d fill=%0d want 1 1 5", edrop[1], pcnt[1], fill_s);
    end
    pl = {8'h21, 8'h22};
    send_frame(1, pl, 1'b1, 1'b0);
    idle(3);
    vectors++;
    if ({pcnt[1], fill_s, edrop[1]} !== {16'd2, 4'd7, 8'd1}) begin
      miscompares++; $display("FAIL nospace_exact_fit: cnt=%0d fill=%0d edrop=%0d want 2 7 1", pcnt[1], fill_s, edrop[1]);
    end
    mrdy[1] = 1'b1;
    idle(12);
    vectors++;
    if (got1.size() != base + 8 || got1[base] !== 8'h01 || got1[base+5] !== 8'h06 ||
        got1[base+6] !== 8'h21 || got1[base+7] !== 8'h22 || fill_s !== 4'd0) begin
      miscompares++; $display("FAIL nospace_drain: bytes=%0d fill=%0d want 8 bytes 01..06 21 22, fill 0", got1.size() - base, fill_s);
    end
  endtask

  task automatic test_back_to_back();
    int base = got2.size(); int dc = done_cnt[2];
    mrdy[2] = 1'b1;
    send(2, HDR); send(2, 8'h02); send(2, 8'hAA); send(2, 8'hBB); send(2, HDR); send(2, 8'h01); send(2, 8'hCC);
    idle(6);
    vectors++;
    if (done_cnt[2] - dc != 2 || pcnt[2] !== 16'd2 || plen[2] !== 8'd1) begin
      miscompares++; $display("FAIL b2b_status: pulses=%0d cnt=%0d len=%0d want 2 2 1", done_cnt[2] - dc, pcnt[2], plen[2]);
    end
    vectors++;
    if (got2.size() != base + 3 || got2[base] !== 8'hAA || got2[base+1] !== 8'hBB || got2[base+2] !== 8'hCC) begin
      miscompares++; $display("FAIL b2b_data: got %0d bytes want AA BB CC", got2.size() - base);
    end
  endtask

  task automatic test_saturate();
    repeat (260) begin send(0, HDR); send(0, 8'h00); exp_drop = sat(exp_drop); end
    repeat (260) begin send(0, HDR); send(0, 8'h01); send(0, 8'h00); send(0, 8'hFF); exp_chk = sat(exp_chk); end
    idle(2);
    vectors++;
    if ({edrop[0], echk[0], pcnt[0]} !== {8'(exp_drop), 8'(exp_chk), 16'(exp_cnt)}) begin
      miscompares++; $display("FAIL saturate: edrop=%0d echk=%0d cnt=%0d want %0d %0d %0d", edrop[0], echk[0], pcnt[0], exp_drop, exp_chk, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    int base;
    send(0, HDR); send(0, 8'h04); send(0, 8'h01); send(0, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({rdy[i], mval[i], done[i], plen[i], pcnt[i], echk[i], edrop[i]} !==
          {1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 8'd0, 8'd0} || {fill_m, fill_s, fill_n} !== '0) begin
        miscompares++; $display("FAIL midreset[%0d]: rdy=%b mval=%b cnt=%0d echk=%0d edrop=%0d fill=%0d want 1 0 0 0 0 0",
                                i, rdy[i], mval[i], pcnt[i], echk[i], edrop[i], fill_m);
      end
    end
    #2 rst_n = 1'b1;
    tick();
    base = got0.size();
    pl = {8'h3C};
    send_frame(0, pl, 1'b1, 1'b0);
    idle(5);
    vectors++;
    if (got0.size() != base + 1 || got0[base] !== 8'h3C || pcnt[0] !== 16'd1) begin
      miscompares++; $display("FAIL midreset_recover: bytes=%0d cnt=%0d want one byte 3C cnt 1", got0.size() - base, pcnt[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rxd[i] = 8'h00; rxv[i] = 1'b0; mrdy[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_timeout();
    test_stall_toggle();
    test_random();
    test_no_space();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
